// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_req_arbiter.
// slave  : the arbiter's view.
// master : the requesters/ALU-side view used by whatever surrounds the arbiter.
interface alu_req_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int RES_WIDTH = 16
) ();
    logic [1:0]           req_valid_i;
    logic [1:0]           req_ready_o;
    logic [2*WIDTH-1:0]   req_a_i;
    logic [2*WIDTH-1:0]   req_b_i;
    logic [5:0]           req_op_i;
    logic [1:0]           rsp_valid_o;
    logic [1:0]           rsp_ready_i;
    logic [RES_WIDTH-1:0] rsp_data_o;
    logic [WIDTH-1:0]     alu_num1_o;
    logic [WIDTH-1:0]     alu_num2_o;
    logic [2:0]           alu_op_o;
    logic [RES_WIDTH-1:0] alu_result_i;
    logic                 busy_o;
    logic                 grant_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i, alu_result_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, alu_num1_o, alu_num2_o,
               alu_op_o, busy_o, grant_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i, alu_result_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, alu_num1_o, alu_num2_o,
               alu_op_o, busy_o, grant_o
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter placing one of two requesters onto a shared ALU,
// waiting a fixed settle time, and handing the captured result back.
module alu_req_arbiter #(
    parameter int WIDTH       = 8,
    parameter int RES_WIDTH   = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    alu_req_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 last_grant_reg;
    logic                 grant_reg;
    logic [WIDTH-1:0]     num1_reg;
    logic [WIDTH-1:0]     num2_reg;
    logic [2:0]           op_reg;
    logic [RES_WIDTH-1:0] rsp_data_reg;
    logic [1:0]           rsp_valid_reg;

    logic [WIDTH-1:0]     a_sel  [2];
    logic [WIDTH-1:0]     b_sel  [2];
    logic [2:0]           op_sel [2];

    logic                 winner;
    logic                 accept;
    logic                 settle_done;
    logic                 rsp_done;
    logic [1:0]           req_ready;

    // Split the packed per-requester payloads into indexable lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_sel[gi]  = bus.req_a_i[gi*WIDTH +: WIDTH];
            assign b_sel[gi]  = bus.req_b_i[gi*WIDTH +: WIDTH];
            assign op_sel[gi] = bus.req_op_i[gi*3 +: 3];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, winner selection and handshake strobes.
    always_comb begin
        state_next  = state_reg;
        winner      = 1'b0;
        accept      = 1'b0;
        settle_done = 1'b0;
        rsp_done    = 1'b0;
        req_ready   = 2'b00;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid_i != 2'b00) begin
                    accept = 1'b1;
                    // On a tie the requester not served last time wins.
                    if (bus.req_valid_i == 2'b11) begin
                        winner = ~last_grant_reg;
                    end else begin
                        winner = bus.req_valid_i[1];
                    end
                    req_ready  = winner ? 2'b10 : 2'b01;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    settle_done = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                // Only the granted requester's ready closes the response.
                if (bus.rsp_ready_i[grant_reg]) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latching, settle counter, result capture and response valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            num1_reg       <= '0;
            num2_reg       <= '0;
            op_reg         <= '0;
            rsp_data_reg   <= '0;
            rsp_valid_reg  <= 2'b00;
        end else begin
            if (accept) begin
                num1_reg       <= a_sel[winner];
                num2_reg       <= b_sel[winner];
                op_reg         <= op_sel[winner];
                grant_reg      <= winner;
                last_grant_reg <= winner;
                cnt_reg        <= CNT_W'(ALU_LATENCY);
            end
            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (settle_done) begin
                rsp_data_reg  <= bus.alu_result_i;
                rsp_valid_reg <= grant_reg ? 2'b10 : 2'b01;
            end
            if (rsp_done) begin
                rsp_valid_reg <= 2'b00;
            end
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_data_o  = rsp_data_reg;
    assign bus.alu_num1_o  = num1_reg;
    assign bus.alu_num2_o  = num2_reg;
    assign bus.alu_op_o    = op_reg;
    assign bus.busy_o      = (state_reg != IDLE);
    assign bus.grant_o     = grant_reg;
endmodule
